// File: rtl/prio_enc_pkg.sv
// Shared constants and result type for the 4-to-2 priority encoder.
// Code values and output reset values live here so every user agrees on them.
package prio_enc_pkg;

  localparam logic [1:0] CODE_I0 = 2'b00;
  localparam logic [1:0] CODE_I1 = 2'b01;
  localparam logic [1:0] CODE_I2 = 2'b10;
  localparam logic [1:0] CODE_I3 = 2'b11;

  localparam logic [1:0] RST_Y = 2'b00;
  localparam logic       RST_V = 1'b0;

  typedef struct packed {
    logic [1:0] code;
    logic       valid;
  } enc_result_t;

  localparam enc_result_t ENC_IDLE = '{code: CODE_I0, valid: 1'b0};

endpackage

// File: rtl/prio_enc_if.sv
// Request-vector / encoded-result bundle between a requester and the encoder.
// The requester owns req; the encoder owns code and valid.
interface prio_enc_if;

  logic [3:0] req;
  logic [1:0] code;
  logic       valid;

  modport master (output req, input code, input valid);
  modport slave  (input req, output code, output valid);

endinterface

// File: rtl/prio_enc4_comb.sv
// Pure combinational 4-input priority encoder, highest index wins.
// Y is meaningful only while valid is high; with no request it idles at CODE_I0.
module prio_enc4_comb
  import prio_enc_pkg::*;
(
  prio_enc_if.slave bus
);

  enc_result_t result;

  // NOTE: the default assignment first guarantees every path drives result, so no latch is inferred.
  always_comb begin
    result = ENC_IDLE;
    if (bus.req[3]) begin
      result = '{code: CODE_I3, valid: 1'b1};
    end else if (bus.req[2]) begin
      result = '{code: CODE_I2, valid: 1'b1};
    end else if (bus.req[1]) begin
      result = '{code: CODE_I1, valid: 1'b1};
    end else if (bus.req[0]) begin
      result = '{code: CODE_I0, valid: 1'b1};
    end
  end

  assign bus.code  = result.code;
  assign bus.valid = result.valid;

endmodule

// File: rtl/priority_encoder_4to2.sv
// Registered 4-input priority encoder: one-cycle latency, asynchronous clear.
// The request lines are gathered onto an internal bus feeding the combinational encoder.
module priority_encoder_4to2
  import prio_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I0,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  output logic [1:0] Y,
  output logic       V
);

  prio_enc_if enc_bus ();

  assign enc_bus.req = {I3, I2, I1, I0};

  prio_enc4_comb u_comb (
    .bus (enc_bus.slave)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= RST_Y;
      V <= RST_V;
    end else begin
      Y <= enc_bus.code;
      V <= enc_bus.valid;
    end
  end

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench for priority_encoder_4to2: directed cases plus random vectors
// compared against a highest-set-bit reference model.
module tb_priority_encoder_4to2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] y_obs;
  logic       v_obs;

  int checks = 0;
  int errors = 0;

  prio_enc_if tb_bus ();

  assign tb_bus.code  = y_obs;
  assign tb_bus.valid = v_obs;

  priority_encoder_4to2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I0    (tb_bus.req[0]),
    .I1    (tb_bus.req[1]),
    .I2    (tb_bus.req[2]),
    .I3    (tb_bus.req[3]),
    .Y     (y_obs),
    .V     (v_obs)
  );

  always #5 clk = ~clk;

  // Expected {V,Y}: index of the highest asserted line, V set if any line is asserted.
  function automatic logic [2:0] ref_model(input logic [3:0] r);
    int hi = -1;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) hi = i;
    end
    if (hi < 0) return 3'b000;
    return {1'b1, 2'(hi)};
  endfunction

  task automatic check(input string tag, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got {V,Y}=%b expected %b", tag, actual, expected);
    end
  endtask

  function automatic logic [2:0] observed();
    return {tb_bus.valid, tb_bus.code};
  endfunction

  // Drive a vector between edges, then check one step after the capturing edge.
  task automatic apply(input string tag, input logic [3:0] vec);
    @(negedge clk);
    tb_bus.req = vec;
    @(posedge clk);
    #1;
    check(tag, observed(), ref_model(vec));
  endtask

  initial begin
    tb_bus.req = 4'b1111;

    // Asynchronous reset before the first clock edge.
    #1 rst_n = 1'b0;
    #1 check("reset_no_edge", observed(), 3'b000);
    repeat (2) @(posedge clk);
    #1 check("reset_held", observed(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_pre_edge", observed(), 3'b000);
    @(posedge clk);
    #1 check("release_first_edge", observed(), 3'b111);

    for (int v = 0; v < 16; v++) begin
      apply($sformatf("sweep_%0d", v), 4'(v));
    end

    // Directed priority masking with literal expectations.
    @(negedge clk) tb_bus.req = 4'b1010;
    @(posedge clk) #1 check("mask_1010", observed(), 3'b111);
    @(negedge clk) tb_bus.req = 4'b0110;
    @(posedge clk) #1 check("mask_0110", observed(), 3'b110);
    @(negedge clk) tb_bus.req = 4'b0011;
    @(posedge clk) #1 check("mask_0011", observed(), 3'b101);
    @(negedge clk) tb_bus.req = 4'b0000;
    @(posedge clk) #1 check("no_request", observed(), 3'b000);
    @(negedge clk) tb_bus.req = 4'b0001;
    @(posedge clk) #1 check("only_i0", observed(), 3'b100);

    // Latency: an input change between edges must not reach the outputs early.
    @(negedge clk) tb_bus.req = 4'b1000;
    #1 check("latency_hold", observed(), 3'b100);
    @(posedge clk) #1 check("latency_update", observed(), 3'b111);

    // Mid-run reset pulse between edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrun_reset", observed(), 3'b000);
    tb_bus.req = 4'b0100;
    #1 rst_n = 1'b1;
    #1 check("midrun_release", observed(), 3'b000);
    @(posedge clk) #1 check("midrun_resume", observed(), 3'b110);

    for (int n = 0; n < 200; n++) begin
      apply("random", 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
